// File: rtl/strip_alloc_if.sv
// Request/response bundle between a strip allocator and its client.
interface strip_alloc_if #(
    parameter int unsigned WW = 7
);
    logic          req_valid;
    logic          req_ready;
    logic [WW-1:0] req_w;
    logic [3:0]    id1;
    logic [3:0]    id2;
    logic [3:0]    id3;
    logic          resp_valid;
    logic          resp_ok;
    logic [3:0]    resp_id;
    logic [WW-1:0] resp_x;

    modport master (
        output req_valid, req_w, id1, id2, id3,
        input  req_ready, resp_valid, resp_ok, resp_id, resp_x
    );

    modport slave (
        input  req_valid, req_w, id1, id2, id3,
        output req_ready, resp_valid, resp_ok, resp_id, resp_x
    );
endinterface

// File: rtl/strip_alloc.sv
// Strip allocator: places an item of width req_w into the first of up to three
// candidate strips (IDs 1..13) with room, returning the strip and offset.
module strip_alloc #(
    parameter int unsigned STRIP_W = 64,
    parameter int unsigned WW      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic busy,
    strip_alloc_if.slave bus
);
    localparam int unsigned NUM_IDS = 16;
    localparam int unsigned SUM_W   = WW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK1 = 3'd1,
        CHK2 = 3'd2,
        CHK3 = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [WW-1:0] used_q [NUM_IDS];
    logic [WW-1:0] w_q;
    logic [3:0]    id1_q, id2_q, id3_q;

    logic          resp_valid_q, resp_ok_q, resp_ok_d;
    logic [3:0]    resp_id_q, resp_id_d;
    logic [WW-1:0] resp_x_q, resp_x_d;
    logic          busy_q;

    logic          latch_en, clr_en, commit_en;
    logic [3:0]    cand_id;
    logic          cand_valid;
    logic [WW-1:0] cand_used;
    logic [SUM_W-1:0] cand_sum;
    logic          hit;

    assign bus.req_ready  = (state_q == IDLE) && !clr;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_ok    = resp_ok_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_x     = resp_x_q;
    assign busy           = busy_q;

    // Candidate for the current check stage and its fit test
    always_comb begin
        cand_id = 4'd0;
        case (state_q)
            CHK1:    cand_id = id1_q;
            CHK2:    cand_id = id2_q;
            CHK3:    cand_id = id3_q;
            default: cand_id = 4'd0;
        endcase
        cand_valid = (cand_id >= 4'd1) && (cand_id <= 4'd13);
        cand_used  = used_q[cand_id];
        cand_sum   = SUM_W'(cand_used) + SUM_W'(w_q);
        hit        = cand_valid && (w_q != '0) && (cand_sum <= SUM_W'(STRIP_W));
    end

    // Next-state and response/commit decisions
    always_comb begin
        state_d   = state_q;
        resp_ok_d = resp_ok_q;
        resp_id_d = resp_id_q;
        resp_x_d  = resp_x_q;
        latch_en  = 1'b0;
        clr_en    = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    clr_en = 1'b1;
                end else if (bus.req_valid) begin
                    latch_en = 1'b1;
                    state_d  = CHK1;
                end
            end
            CHK1, CHK2, CHK3: begin
                if (hit) begin
                    resp_ok_d = 1'b1;
                    resp_id_d = cand_id;
                    resp_x_d  = cand_used;
                    commit_en = 1'b1;
                    state_d   = RESP;
                end else if (state_q == CHK1) begin
                    state_d = CHK2;
                end else if (state_q == CHK2) begin
                    state_d = CHK3;
                end else begin
                    resp_ok_d = 1'b0;
                    resp_id_d = 4'd0;
                    resp_x_d  = '0;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            w_q          <= '0;
            id1_q        <= 4'd0;
            id2_q        <= 4'd0;
            id3_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= 4'd0;
            resp_x_q     <= '0;
            busy_q       <= 1'b0;
            for (int k = 0; k < NUM_IDS; k++) used_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_d == RESP);
            busy_q       <= (state_d != IDLE);
            resp_ok_q    <= resp_ok_d;
            resp_id_q    <= resp_id_d;
            resp_x_q     <= resp_x_d;
            if (latch_en) begin
                w_q   <= bus.req_w;
                id1_q <= bus.id1;
                id2_q <= bus.id2;
                id3_q <= bus.id3;
            end
            if (clr_en) begin
                for (int k = 0; k < NUM_IDS; k++) used_q[k] <= '0;
            end else if (commit_en) begin
                // Sum is bounded by STRIP_W, so it always fits in WW bits
                used_q[cand_id] <= WW'(cand_sum);
            end
        end
    end
endmodule

// File: tb/tb_strip_alloc.sv
// Directed self-checking bench for strip_alloc with hand-computed expectations.
module tb_strip_alloc;
    localparam int unsigned STRIP_W = 64;
    localparam int unsigned WW      = 7;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    strip_alloc_if #(.WW(WW)) bus ();

    strip_alloc #(.STRIP_W(STRIP_W), .WW(WW)) dut (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge, measure latency to resp_valid and check the response
    task automatic do_req(input string tag, input logic [6:0] w, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c, input int exp_lat,
                          input logic exp_ok, input logic [3:0] exp_id, input logic [6:0] exp_x);
        int lat;
        lat = 0;
        bus.req_valid = 1'b1;
        bus.req_w     = w;
        bus.id1       = a;
        bus.id2       = b;
        bus.id3       = c;
        #1;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        for (int cy = 1; cy <= 8; cy++) begin
            @(negedge clk);
            if (cy == 1) begin
                bus.req_valid = 1'b0;
                bus.req_w     = '0;
                bus.id1       = 4'd0;
                bus.id2       = 4'd0;
                bus.id3       = 4'd0;
                check({tag, ".busy"}, 32'(busy), 32'd1);
                check({tag, ".ready_low"}, 32'(bus.req_ready), 32'd0);
            end
            if (bus.resp_valid === 1'b1) begin
                lat = cy;
                break;
            end
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".ok"}, 32'(bus.resp_ok), 32'(exp_ok));
        check({tag, ".id"}, 32'(bus.resp_id), 32'(exp_id));
        check({tag, ".x"}, 32'(bus.resp_x), 32'(exp_x));
        @(negedge clk);
        check({tag, ".strobe"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        clr           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_w     = '0;
        bus.id1       = 4'd0;
        bus.id2       = 4'd0;
        bus.id3       = 4'd0;
        repeat (2) @(negedge clk);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.ok", 32'(bus.resp_ok), 32'd0);
        check("rst.id", 32'(bus.resp_id), 32'd0);
        check("rst.x", 32'(bus.resp_x), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // Packing onto strip 10 then spill to strip 8
        do_req("a1", 7'd20, 4'd10, 4'd8, 4'd0, 2, 1'b1, 4'd10, 7'd0);
        do_req("a2", 7'd20, 4'd10, 4'd8, 4'd0, 2, 1'b1, 4'd10, 7'd20);
        do_req("a3", 7'd20, 4'd10, 4'd8, 4'd0, 2, 1'b1, 4'd10, 7'd40);
        do_req("a4", 7'd20, 4'd10, 4'd8, 4'd0, 3, 1'b1, 4'd8,  7'd0);
        do_req("exact", 7'd4, 4'd10, 4'd0, 4'd0, 2, 1'b1, 4'd10, 7'd60);
        do_req("full", 7'd1, 4'd10, 4'd8, 4'd0, 3, 1'b1, 4'd8, 7'd20);

        // Invalid candidates
        do_req("none", 7'd5, 4'd0, 4'd0, 4'd0, 4, 1'b0, 4'd0, 7'd0);
        do_req("bad_ids", 7'd5, 4'd14, 4'd15, 4'd0, 4, 1'b0, 4'd0, 7'd0);
        do_req("s8_fill", 7'd43, 4'd8, 4'd0, 4'd0, 2, 1'b1, 4'd8, 7'd21);

        // Width boundaries
        do_req("w64", 7'd64, 4'd1, 4'd0, 4'd0, 2, 1'b1, 4'd1, 7'd0);
        do_req("w1_full", 7'd1, 4'd1, 4'd0, 4'd0, 4, 1'b0, 4'd0, 7'd0);
        do_req("w0", 7'd0, 4'd2, 4'd0, 4'd0, 4, 1'b0, 4'd0, 7'd0);
        do_req("w65", 7'd65, 4'd3, 4'd0, 4'd0, 4, 1'b0, 4'd0, 7'd0);

        // Duplicate candidates; a miss must leave strip 2 at 30
        do_req("dup_hit", 7'd30, 4'd2, 4'd2, 4'd2, 2, 1'b1, 4'd2, 7'd0);
        do_req("dup_miss", 7'd40, 4'd2, 4'd2, 4'd2, 4, 1'b0, 4'd0, 7'd0);
        do_req("dup_after", 7'd34, 4'd2, 4'd0, 4'd0, 2, 1'b1, 4'd2, 7'd30);
        do_req("id3_hit", 7'd10, 4'd1, 4'd10, 4'd4, 4, 1'b1, 4'd4, 7'd0);

        // clr together with a request: clear only, nothing accepted
        clr           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_w     = 7'd5;
        bus.id1       = 4'd10;
        #1;
        check("clr.ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        clr           = 1'b0;
        bus.req_valid = 1'b0;
        bus.id1       = 4'd0;
        check("clr.busy", 32'(busy), 32'd0);
        check("clr.resp_valid", 32'(bus.resp_valid), 32'd0);
        do_req("clr_s10", 7'd30, 4'd10, 4'd0, 4'd0, 2, 1'b1, 4'd10, 7'd0);
        do_req("clr_s1", 7'd64, 4'd1, 4'd0, 4'd0, 2, 1'b1, 4'd1, 7'd0);

        // Reset while in CHK2 aborts the request
        bus.req_valid = 1'b1;
        bus.req_w     = 7'd10;
        bus.id2       = 4'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.id2       = 4'd0;
        @(negedge clk);
        check("abort.busy_chk2", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.ok", 32'(bus.resp_ok), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort.no_resp", 32'(bus.resp_valid), 32'd0);
            @(negedge clk);
        end
        do_req("post_rst", 7'd10, 4'd5, 4'd0, 4'd0, 2, 1'b1, 4'd5, 7'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/strip_alloc.md
STRIP_ALLOC -- requirements
Module: strip_alloc

Interface
REQ-001 Parameter STRIP_W, default 64, usable width of every strip in units.
REQ-002 Parameter WW, default 7, bit width of width/offset fields; SHALL satisfy 2^WW > STRIP_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clr  input  1  clears all strip fill levels; honoured only in IDLE.
REQ-006 req_valid  input  1  allocation request present.
REQ-007 req_ready  output  1  combinational; equals (state==IDLE) AND NOT clr.
REQ-008 req_w  input  WW  requested item width.
REQ-009 id1, id2, id3  input  4 each  candidate strip IDs, id1 highest priority; value 0 means no candidate.
REQ-010 resp_valid  output  1  registered, one-cycle response strobe.
REQ-011 resp_ok  output  1  registered, 1 = allocation made.
REQ-012 resp_id  output  4  registered, strip allocated; 0 on failure.
REQ-013 resp_x  output  WW  registered, offset of item within the strip; 0 on failure.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 Block SHALL hold a fill level used[k] of width WW for strips k = 1..13; IDs 0, 14, 15 are invalid.
REQ-016 FSM states: IDLE, CHK1, CHK2, CHK3, RESP.
REQ-017 IDLE: on req_valid AND req_ready, latch req_w, id1, id2, id3 and go to CHK1.
REQ-018 IDLE with clr=1: set all used[k] to 0 on that edge, accept no request, stay in IDLE.
REQ-019 CHKn hit condition: latched idn valid AND req_w != 0 AND used[idn] + req_w <= STRIP_W, with the sum evaluated at WW+1 bits.
REQ-020 CHKn hit: register resp_ok=1, resp_id=idn, resp_x=used[idn]; set used[idn] to used[idn]+req_w; go to RESP.
REQ-021 CHKn miss: CHK1 goes to CHK2, CHK2 goes to CHK3; CHK3 registers resp_ok=0, resp_id=0, resp_x=0 and goes to RESP.
REQ-022 RESP: resp_valid=1 for exactly this one cycle; next state IDLE; resp_ok/id/x hold until the next response is registered.
REQ-023 Latency, request accepted at the edge ending cycle 0: resp_valid is high in cycle 2 on an id1 hit, cycle 3 on an id2 hit, cycle 4 on an id3 hit or a failure.
REQ-024 Exact fit (used + req_w == STRIP_W) SHALL be a hit; a strip with used == STRIP_W SHALL miss for any req_w >= 1.
REQ-025 req_w == 0 or req_w > STRIP_W SHALL miss every check, giving a failure response in cycle 4.
REQ-026 Duplicate candidate IDs are each rechecked with identical result; no fill level changes on a miss.
REQ-027 At most one used[] entry changes per request; clr is ignored outside IDLE.
REQ-028 Throughput: at most one request per 3 to 5 cycles; req_ready is low from CHK1 through RESP.

Reset
REQ-029 rst=1 SHALL force state IDLE, all used[k]=0, resp_valid=0, resp_ok=0, resp_id=0, resp_x=0, busy=0 on the next edge.
REQ-030 rst SHALL take priority over clr and any request in flight; an aborted request produces no resp_valid and commits no fill update.

Verification
REQ-031 After reset, req_w=20 with ids (10,8,0) -> cycle 2: resp_valid=1, ok=1, id=10, x=0.
REQ-032 Four successive requests of w=20 with ids (10,8,0) -> x=0, 20, 40 on strip 10 (cycle 2 each); fourth -> id=8, x=0 in cycle 3.
REQ-033 ids (0,0,0), or ids (14,15,0), with w=5 -> cycle 4: ok=0, id=0, x=0; no used[] change.
REQ-034 w=64 to strip 1 -> ok, x=0; then w=1 with ids (1,0,0) -> failure in cycle 4; w=0 with ids (2,0,0) -> failure in cycle 4.
REQ-035 clr=1 and req_valid=1 together in IDLE -> req_ready=0 and fill levels cleared; following request w=30 with ids (10,0,0) -> x=0.
REQ-036 rst asserted during CHK2 -> no resp_valid follows; a subsequent request w=10 with ids (5,0,0) -> ok, x=0.
